// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - frame-buffer RAM port, host write port and video outputs of vga_scanout
interface vga_scanout_if;
    logic [9:0] addr;
    logic [3:0] din;
    logic       write_en;
    logic [3:0] ram_dout;
    logic       wr_req;
    logic [9:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [3:0] color;
    logic       frame_start;

    modport master (
        output addr, din, write_en, wr_ack,
        output hsync, vsync, de, color, frame_start,
        input  ram_dout, wr_req, wr_addr, wr_data
    );

    modport slave (
        input  addr, din, write_en, wr_ack,
        input  hsync, vsync, de, color, frame_start,
        output ram_dout, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing and cell-mapped frame-buffer scanout; SCANOUT_BORDER_EN forces a 4'hF border
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL_W   = 20,
    parameter int CELL_H   = 15
) (
    input  logic          mem_clk,
    input  logic          rst_n,
    vga_scanout_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SXW     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int SYW     = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT     = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  H_X_LAST  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0]  H_SYNC_S  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  H_SYNC_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT     = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_Y_LAST  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]  V_SYNC_S  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  V_SYNC_E  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SXW-1:0] SX_LAST   = SXW'(CELL_W - 1);
    localparam logic [SYW-1:0] SY_LAST   = SYW'(CELL_H - 1);

    logic [HW-1:0]  r_h_cnt;
    logic [VW-1:0]  r_v_cnt;
    logic [SXW-1:0] r_sub_x;
    logic [SYW-1:0] r_sub_y;
    logic [4:0]     r_cell_col;
    logic [4:0]     r_cell_row;

    logic r_de1, r_hs1, r_vs1, r_fs1, r_bd1;
    logic r_de2, r_hs2, r_vs2, r_fs2;
    logic [3:0] r_color;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active;
    logic w_line_active;
    logic w_hsync;
    logic w_vsync;
    logic w_frame_start;
    logic w_border;
    logic w_wr_go;

    assign w_h_wrap      = (r_h_cnt == H_LAST);
    assign w_v_wrap      = (r_v_cnt == V_LAST);
    assign w_line_active = (r_v_cnt < V_ACT);
    assign w_active      = (r_h_cnt < H_ACT) && w_line_active;
    assign w_hsync       = !((r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E));
    assign w_vsync       = !((r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E));
    assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef SCANOUT_BORDER_EN
    assign w_border = w_active && ((r_h_cnt == '0) || (r_h_cnt == H_X_LAST) ||
                                   (r_v_cnt == '0) || (r_v_cnt == V_Y_LAST));
`else
    assign w_border = 1'b0;
`endif

    // Host writes borrow the RAM port only while the beam is blanked; rst_n gates them off at once.
    assign w_wr_go      = rst_n && bus.wr_req && !w_active;
    assign bus.write_en = w_wr_go;
    assign bus.wr_ack   = w_wr_go;
    assign bus.din      = w_wr_go ? bus.wr_data : 4'h0;
    assign bus.addr     = w_wr_go ? bus.wr_addr : {r_cell_row, r_cell_col};

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub_x    <= '0;
            r_cell_col <= '0;
        end else if (w_h_wrap) begin
            r_sub_x    <= '0;
            r_cell_col <= '0;
        end else if (w_active) begin
            if (r_sub_x == SX_LAST) begin
                r_sub_x    <= '0;
                r_cell_col <= r_cell_col + 1'b1;
            end else begin
                r_sub_x <= r_sub_x + 1'b1;
            end
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub_y    <= '0;
            r_cell_row <= '0;
        end else if (w_h_wrap) begin
            if (w_v_wrap) begin
                r_sub_y    <= '0;
                r_cell_row <= '0;
            end else if (w_line_active) begin
                if (r_sub_y == SY_LAST) begin
                    r_sub_y    <= '0;
                    r_cell_row <= r_cell_row + 1'b1;
                end else begin
                    r_sub_y <= r_sub_y + 1'b1;
                end
            end
        end
    end

    // Stage 1 waits out the RAM read; stage 2 lands alongside the registered colour.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de1   <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_fs1   <= 1'b0;
            r_bd1   <= 1'b0;
            r_de2   <= 1'b0;
            r_hs2   <= 1'b1;
            r_vs2   <= 1'b1;
            r_fs2   <= 1'b0;
            r_color <= 4'h0;
        end else begin
            r_de1 <= w_active;
            r_hs1 <= w_hsync;
            r_vs1 <= w_vsync;
            r_fs1 <= w_frame_start;
            r_bd1 <= w_border;
            r_de2 <= r_de1;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_fs2 <= r_fs1;
            if (!r_de1) begin
                r_color <= 4'h0;
            end else if (r_bd1) begin
                r_color <= 4'hF;
            end else begin
                r_color <= bus.ram_dout;
            end
        end
    end

    assign bus.hsync       = r_hs2;
    assign bus.vsync       = r_vs2;
    assign bus.de          = r_de2;
    assign bus.frame_start = r_fs2;
    assign bus.color       = r_color;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench for vga_scanout on a reduced raster; border expectations follow SCANOUT_BORDER_EN
module tb_vga_scanout;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 12, VF = 1, VS = 2, VB = 1;
    localparam int CW = 4, CH = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_scanout_if bus ();

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .CELL_W   (CW), .CELL_H (CH)
    ) dut (
        .mem_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] ram [0:1023];
    logic [3:0] ram_q;
    logic       ld_en;
    logic [9:0] ld_addr;
    logic [3:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (bus.write_en) begin
            ram[bus.addr] <= bus.din;
        end
        ram_q <= ram[bus.addr];
    end
    assign bus.ram_dout = ram_q;

    logic [3:0] exp_mem [0:1023];
    logic [9:0] wa [4];
    logic [3:0] wd [4];
    int n_vec = 0;
    int n_err = 0;
    int k = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic goto_cnt(input int c);
        int n;
        n = ((c - (k % FR)) + FR) % FR;
        if (n == 0) n = FR;
        repeat (n) cyc();
    endtask

    task automatic check_pixel(input int p);
        int x, y;
        logic e_de, e_hs, e_vs, e_fs;
        logic [3:0] e_col;
        x     = p % HT;
        y     = (p / HT) % VT;
        e_de  = (x < HA) && (y < VA);
        e_hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        e_vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        e_fs  = ((p % FR) == 0);
        e_col = e_de ? exp_mem[(y / CH) * 32 + (x / CW)] : 4'h0;
`ifdef SCANOUT_BORDER_EN
        if (e_de && (x == 0 || x == HA - 1 || y == 0 || y == VA - 1)) e_col = 4'hF;
`endif
        chk($sformatf("de(%0d,%0d)", x, y),    32'(bus.de),          32'(e_de));
        chk($sformatf("hsync(%0d,%0d)", x, y), 32'(bus.hsync),       32'(e_hs));
        chk($sformatf("vsync(%0d,%0d)", x, y), 32'(bus.vsync),       32'(e_vs));
        chk($sformatf("fs(%0d,%0d)", x, y),    32'(bus.frame_start), 32'(e_fs));
        chk($sformatf("color(%0d,%0d)", x, y), 32'(bus.color),       32'(e_col));
    endtask

    task automatic check_frame();
        int hs_lo, vs_lo, de_hi, fs_n;
        hs_lo = 0; vs_lo = 0; de_hi = 0; fs_n = 0;
        bus.wr_req = 1'b0;
        goto_cnt(2);
        for (int p = 0; p < FR; p++) begin
            if (p > 0) cyc();
            smp();
            check_pixel(p);
            if (!bus.hsync) hs_lo++;
            if (!bus.vsync) vs_lo++;
            if (bus.de) de_hi++;
            if (bus.frame_start) fs_n++;
        end
        chk("hsync_low_cycles", hs_lo, HS * VT);
        chk("vsync_low_cycles", vs_lo, VS * HT);
        chk("de_high_cycles",   de_hi, HA * VA);
        chk("frame_start_count", fs_n, 1);
    endtask

    initial begin
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        rst_n = 1'b0;

        for (int i = 0; i < 1024; i++) exp_mem[i] = 4'((i * 7 + 3) & 15);
        exp_mem[0]  = 4'hA;
        exp_mem[33] = 4'h5;

        ld_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            ld_addr = 10'(i);
            ld_data = exp_mem[i];
            cyc();
        end
        ld_en = 1'b0;

        bus.wr_req = 1'b1; bus.wr_addr = 10'd40; bus.wr_data = 4'h6;
        smp();
        chk("rst_hsync",    32'(bus.hsync),       1);
        chk("rst_vsync",    32'(bus.vsync),       1);
        chk("rst_de",       32'(bus.de),          0);
        chk("rst_color",    32'(bus.color),       0);
        chk("rst_fs",       32'(bus.frame_start), 0);
        chk("rst_write_en", 32'(bus.write_en),    0);
        chk("rst_wr_ack",   32'(bus.wr_ack),      0);
        chk("rst_din",      32'(bus.din),         0);

        cyc();
        rst_n = 1'b1;
        k = 0;
        smp();
        chk("release_ack",      32'(bus.wr_ack),   0);
        chk("release_write_en", 32'(bus.write_en), 0);
        bus.wr_req = 1'b0;

        check_frame();

        goto_cnt(2 * HT + 5);
        bus.wr_req = 1'b1; bus.wr_addr = 10'd67; bus.wr_data = 4'hC;
        for (int h = 5; h < HA; h++) begin
            smp();
            chk($sformatf("stall_ack h=%0d", h),  32'(bus.wr_ack),   0);
            chk($sformatf("stall_we h=%0d", h),   32'(bus.write_en), 0);
            chk($sformatf("stall_addr h=%0d", h), 32'(bus.addr),     (2 / CH) * 32 + h / CW);
            cyc();
        end
        smp();
        chk("stall_release_ack",  32'(bus.wr_ack),   1);
        chk("stall_release_we",   32'(bus.write_en), 1);
        chk("stall_release_addr", 32'(bus.addr),     67);
        chk("stall_release_din",  32'(bus.din),      32'hC);
        cyc();
        bus.wr_req = 1'b0;
        exp_mem[67] = 4'hC;
        smp();
        chk("stall_after_ack", 32'(bus.wr_ack), 0);

        wa[0] = 10'd1;  wd[0] = 4'h7;
        wa[1] = 10'd99; wd[1] = 4'hE;
        wa[2] = 10'd34; wd[2] = 4'h9;
        wa[3] = 10'd64; wd[3] = 4'h3;
        goto_cnt(12 * HT + 2);
        for (int i = 0; i < 4; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = wa[i]; bus.wr_data = wd[i];
            smp();
            chk($sformatf("burst_ack%0d", i),  32'(bus.wr_ack),   1);
            chk($sformatf("burst_we%0d", i),   32'(bus.write_en), 1);
            chk($sformatf("burst_addr%0d", i), 32'(bus.addr),     32'(wa[i]));
            chk($sformatf("burst_din%0d", i),  32'(bus.din),      32'(wd[i]));
            cyc();
            exp_mem[wa[i]] = wd[i];
        end
        bus.wr_req = 1'b0;
        smp();
        chk("burst_idle_ack", 32'(bus.wr_ack), 0);

        check_frame();

        goto_cnt(5 * HT + 10);
        bus.wr_req = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 4'h2;
        smp();
        chk("pre_reset_de", 32'(bus.de), 1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst_hsync",    32'(bus.hsync),       1);
        chk("midrst_vsync",    32'(bus.vsync),       1);
        chk("midrst_de",       32'(bus.de),          0);
        chk("midrst_color",    32'(bus.color),       0);
        chk("midrst_fs",       32'(bus.frame_start), 0);
        chk("midrst_write_en", 32'(bus.write_en),    0);
        chk("midrst_wr_ack",   32'(bus.wr_ack),      0);
        chk("midrst_din",      32'(bus.din),         0);
        repeat (3) cyc();
        rst_n = 1'b1;
        k = 0;
        smp();
        chk("midrst_release_ack", 32'(bus.wr_ack), 0);
        bus.wr_req = 1'b0;

        check_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
